// File: rtl/i2s_frame_assembler_if.sv
// Bundle between the I2S receive codec, the frame assembler and the downstream EQ.
// slave: the assembler side; master: the side that drives samples and consumes frames.
interface i2s_frame_assembler_if #(
  parameter int OUT_W = 16
);
  logic [31:0]      sample_dat_i;
  logic             sample_vld_i;
  logic             ws_i;
  logic [OUT_W-1:0] frame_l_o;
  logic [OUT_W-1:0] frame_r_o;
  logic             frame_vld_o;
  logic             frame_rdy_i;
  logic             sync_o;
  logic             overflow_o;
  logic [7:0]       drop_cnt_o;

  modport slave (
    input  sample_dat_i, sample_vld_i, ws_i, frame_rdy_i,
    output frame_l_o, frame_r_o, frame_vld_o, sync_o, overflow_o, drop_cnt_o
  );

  modport master (
    output sample_dat_i, sample_vld_i, ws_i, frame_rdy_i,
    input  frame_l_o, frame_r_o, frame_vld_o, sync_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/i2s_frame_assembler.sv
// Pairs I2S left/right samples into narrowed stereo frames and queues them in a FWFT FIFO.
// Define FRAME_ASM_SAT_ROUND_EN for round-half-up with positive saturation instead of truncation.
module i2s_frame_assembler #(
  parameter int IN_W       = 24,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   lmmi_clk_i,
  input  logic                   reset_n_i,
  i2s_frame_assembler_if.slave   bus
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam int              SHIFT   = IN_W - OUT_W;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {HUNT, WAIT_R, WAIT_L} state_t;

  state_t           state;
  logic [OUT_W-1:0] held_l;
  logic [OUT_W-1:0] sample_nar;
  logic             sync_q;
  logic             overflow_q;
  logic [7:0]       drop_cnt_q;

  logic [OUT_W-1:0] mem_l [FIFO_DEPTH];
  logic [OUT_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic empty, full, push, pop, push_ok, ovf_evt, misalign;

`ifdef FRAME_ASM_SAT_ROUND_EN
  localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  logic [IN_W:0] rounded;
  logic          unused_bits;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    rounded = {bus.sample_dat_i[IN_W-1], bus.sample_dat_i[IN_W-1:0]} + HALF;
    // Only a positive input can overflow: the guard bit stays 0 while the MSB flips.
    if (!rounded[IN_W] && rounded[IN_W-1]) sample_nar = {1'b0, {(OUT_W-1){1'b1}}};
    else                                   sample_nar = rounded[IN_W-1:SHIFT];
  end

  assign unused_bits = ^{bus.sample_dat_i, rounded[SHIFT-1:0]};
`else
  logic unused_bits;

  assign sample_nar  = bus.sample_dat_i[IN_W-1 -: OUT_W];
  assign unused_bits = ^bus.sample_dat_i;
`endif

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop      = !empty && bus.frame_rdy_i;
  assign push     = bus.sample_vld_i && bus.ws_i && (state == WAIT_R);
  assign push_ok  = push && (!full || pop);
  assign ovf_evt  = push && full && !pop;
  assign misalign = bus.sample_vld_i &&
                    (((state == WAIT_R) && !bus.ws_i) || ((state == WAIT_L) && bus.ws_i));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge lmmi_clk_i) begin
    if (!reset_n_i) begin
      state      <= HUNT;
      held_l     <= '0;
      sync_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (bus.sample_vld_i) begin
        case (state)
          HUNT: begin
            if (!bus.ws_i) begin
              held_l <= sample_nar;
              state  <= WAIT_R;
              sync_q <= 1'b1;
            end
          end
          WAIT_R: begin
            if (bus.ws_i) state  <= WAIT_L;
            else          held_l <= sample_nar;
          end
          WAIT_L: begin
            if (!bus.ws_i) begin
              held_l <= sample_nar;
              state  <= WAIT_R;
            end else begin
              state  <= HUNT;
              sync_q <= 1'b0;
            end
          end
          default: begin
            state  <= HUNT;
            sync_q <= 1'b0;
          end
        endcase
      end
      if (ovf_evt) overflow_q <= 1'b1;
      if ((misalign || ovf_evt) && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge lmmi_clk_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; an empty count already masks stale entries at the outputs.
  always_ff @(posedge lmmi_clk_i) begin
    if (push_ok) begin
      mem_l[wr_ptr] <= held_l;
      mem_r[wr_ptr] <= sample_nar;
    end
  end

  assign bus.frame_vld_o = !empty;
  assign bus.frame_l_o   = empty ? '0 : mem_l[rd_ptr];
  assign bus.frame_r_o   = empty ? '0 : mem_r[rd_ptr];
  assign bus.sync_o      = sync_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_i2s_frame_assembler.sv
// Self-checking bench for i2s_frame_assembler: a queue-based frame model checked every cycle,
// plus directed sequences with literal expectations. Honours FRAME_ASM_SAT_ROUND_EN.
module tb_i2s_frame_assembler;

  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  i2s_frame_assembler_if #(.OUT_W(16)) bus ();

  i2s_frame_assembler #(.IN_W(24), .OUT_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .lmmi_clk_i (clk),
    .reset_n_i  (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_narrow(input logic [31:0] d);
    int s;
    s = $signed(d[23:0]);
`ifdef FRAME_ASM_SAT_ROUND_EN
    s = (s + 128) >>> 8;
    if (s > 32767) s = 32767;
`else
    s = s >>> 8;
`endif
    return s[15:0];
  endfunction

  // Model: pending left sample, lock flag, frame queue, drop/overflow counters.
  frame_t      m_q[$];
  bit          m_have_l, m_locked, m_ovf;
  logic [15:0] m_held;
  int          m_drops;

  always @(posedge clk) begin : model
    bit     do_pop;
    bit     do_push;
    frame_t f;
    if (!rst_n) begin
      m_q.delete();
      m_have_l = 1'b0;
      m_locked = 1'b0;
      m_ovf    = 1'b0;
      m_held   = '0;
      m_drops  = 0;
    end else begin
      do_pop  = (m_q.size() != 0) && bus.frame_rdy_i;
      do_push = 1'b0;
      f.l     = '0;
      f.r     = '0;
      if (bus.sample_vld_i) begin
        if (!bus.ws_i) begin
          if (m_have_l) m_drops++;
          m_have_l = 1'b1;
          m_locked = 1'b1;
          m_held   = model_narrow(bus.sample_dat_i);
        end else if (m_have_l) begin
          do_push  = 1'b1;
          f.l      = m_held;
          f.r      = model_narrow(bus.sample_dat_i);
          m_have_l = 1'b0;
        end else if (m_locked) begin
          m_drops++;
          m_locked = 1'b0;
        end
      end
      if (do_push) begin
        if (m_q.size() < DEPTH || do_pop) m_q.push_back(f);
        else begin
          m_ovf = 1'b1;
          m_drops++;
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (m_drops > 255) m_drops = 255;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("frame_vld", bus.frame_vld_o, 32'(m_q.size() != 0));
      check("frame_l",   bus.frame_l_o,   (m_q.size() != 0) ? m_q[0].l : 16'h0);
      check("frame_r",   bus.frame_r_o,   (m_q.size() != 0) ? m_q[0].r : 16'h0);
      check("sync",      bus.sync_o,      m_locked);
      check("overflow",  bus.overflow_o,  m_ovf);
      check("drop_cnt",  bus.drop_cnt_o,  m_drops);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe(input logic w, input logic [31:0] d);
    bus.sample_vld_i = 1'b1;
    bus.ws_i         = w;
    bus.sample_dat_i = d;
    tick();
    bus.sample_vld_i = 1'b0;
    bus.ws_i         = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  logic [23:0] nv  [4] = '{24'h000080, 24'h000180, 24'hFFFF80, 24'h7FFFFF};
`ifdef FRAME_ASM_SAT_ROUND_EN
  logic [15:0] nexp[4] = '{16'h0001, 16'h0002, 16'h0000, 16'h7FFF};
  localparam logic [15:0] T1_R = 16'hFEDD;
`else
  logic [15:0] nexp[4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF};
  localparam logic [15:0] T1_R = 16'hFEDC;
`endif

  initial begin
    rst_n            = 1'b0;
    bus.sample_dat_i = '0;
    bus.sample_vld_i = 1'b0;
    bus.ws_i         = 1'b0;
    bus.frame_rdy_i  = 1'b0;
    do_reset();

    // Reset state
    check("rst_vld", bus.frame_vld_o, 0);
    check("rst_l", bus.frame_l_o, 0);
    check("rst_sync", bus.sync_o, 0);
    check("rst_drop", bus.drop_cnt_o, 0);

    // Basic pairing, one-cycle latency, pop
    bus.frame_rdy_i = 1'b1;
    strobe(1'b0, 32'h00123456);
    check("t1_sync", bus.sync_o, 1);
    check("t1_vld_early", bus.frame_vld_o, 0);
    strobe(1'b1, 32'h00FEDCBA);
    check("t1_vld", bus.frame_vld_o, 1);
    check("t1_l", bus.frame_l_o, 16'h1234);
    check("t1_r", bus.frame_r_o, T1_R);
    tick();
    check("t1_popped", bus.frame_vld_o, 0);
    check("t1_drop", bus.drop_cnt_o, 0);

    // R, L, L, R from HUNT
    do_reset();
    strobe(1'b1, 32'h00111111);
    check("t2_ignore_sync", bus.sync_o, 0);
    check("t2_ignore_drop", bus.drop_cnt_o, 0);
    strobe(1'b0, 32'h000A0000);
    check("t2_sync", bus.sync_o, 1);
    strobe(1'b0, 32'h000B0000);
    check("t2_drop", bus.drop_cnt_o, 1);
    strobe(1'b1, 32'h000C0000);
    check("t2_l", bus.frame_l_o, 16'h0B00);
    check("t2_r", bus.frame_r_o, 16'h0C00);

    // Overflow with consumer stalled, then drain in order
    do_reset();
    bus.frame_rdy_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      strobe(1'b0, (32'h10 + i) << 16);
      strobe(1'b1, (32'h20 + i) << 16);
    end
    check("t3_ovf", bus.overflow_o, 1);
    check("t3_drop", bus.drop_cnt_o, 1);
    bus.frame_rdy_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t3_drain_l", bus.frame_l_o, 32'h1000 + i * 32'h100);
      check("t3_drain_r", bus.frame_r_o, 32'h2000 + i * 32'h100);
      tick();
    end
    check("t3_empty", bus.frame_vld_o, 0);

    // Full FIFO with simultaneous push and pop
    bus.frame_rdy_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      strobe(1'b0, (32'h30 + i) << 16);
      strobe(1'b1, (32'h40 + i) << 16);
    end
    strobe(1'b0, 32'h00350000);
    bus.frame_rdy_i = 1'b1;
    strobe(1'b1, 32'h00450000);
    bus.frame_rdy_i = 1'b0;
    check("t4_drop", bus.drop_cnt_o, 1);
    check("t4_head", bus.frame_l_o, 16'h3200);
    bus.frame_rdy_i = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("t4_drain", bus.frame_l_o, 32'h3000 + i * 32'h100);
      tick();
    end
    check("t4_empty", bus.frame_vld_o, 0);

    // Narrowing boundaries; upper byte of the codec word is ignored
    do_reset();
    bus.frame_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(1'b0, {8'hA5, nv[i]});
      strobe(1'b1, {8'h5A, nv[i]});
      check("t5_narrow_l", bus.frame_l_o, nexp[i]);
      check("t5_narrow_r", bus.frame_r_o, nexp[i]);
    end

    // drop_cnt saturation
    do_reset();
    for (int i = 0; i < 260; i++) strobe(1'b0, 32'h0);
    check("t6_sat", bus.drop_cnt_o, 255);

    // Reset mid-frame with frames queued
    do_reset();
    bus.frame_rdy_i = 1'b0;
    strobe(1'b0, 32'h00010000);
    strobe(1'b0, 32'h00020000);
    strobe(1'b1, 32'h00030000);
    strobe(1'b0, 32'h00040000);
    strobe(1'b1, 32'h00050000);
    strobe(1'b0, 32'h00060000);
    check("t7_pre_vld", bus.frame_vld_o, 1);
    check("t7_pre_drop", bus.drop_cnt_o, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t7_vld", bus.frame_vld_o, 0);
    check("t7_sync", bus.sync_o, 0);
    check("t7_drop", bus.drop_cnt_o, 0);
    check("t7_ovf", bus.overflow_o, 0);
    strobe(1'b1, 32'h00070000);
    check("t7_r_ignored_vld", bus.frame_vld_o, 0);
    check("t7_r_ignored_sync", bus.sync_o, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_frame_assembler.md
# i2s_frame_assembler

Sits between the I2S receive codec and the three-band EQ. Takes the codec's per-channel sample strobes and the word-select line, and pairs left/right samples into stereo frames. It narrows each sample from IN_W to OUT_W bits and buffers frames in a small FIFO with a valid/ready handshake toward the filter. It also detects channel misalignment and FIFO overflow, and reports both.

## Interface

Parameters:
- IN_W, 24, significant bits of sample_dat_i (signed, LSB-aligned)
- OUT_W, 16, width of each output channel sample; OUT_W < IN_W
- FIFO_DEPTH, 4, frame FIFO depth; power of two, ≥ 2

Ports:
- lmmi_clk_i  in  1  system clock; all logic on its rising edge
- reset_n_i  in  1  reset, synchronous, active-low
- sample_dat_i  in  32  codec receive word; bits [IN_W-1:0] are the signed sample
- sample_vld_i  in  1  one-cycle strobe (codec mem_rdwr_o); sample_dat_i valid this cycle
- ws_i  in  1  word select, sampled in the strobe cycle; 0 = left, 1 = right
- frame_l_o  out  OUT_W  left sample at the FIFO head
- frame_r_o  out  OUT_W  right sample at the FIFO head
- frame_vld_o  out  1  FIFO non-empty
- frame_rdy_i  in  1  consumer accepts the head frame when high together with frame_vld_o
- sync_o  out  1  high when the channel tracker is locked (state ≠ HUNT)
- overflow_o  out  1  sticky; a completed frame was dropped because the FIFO was full
- drop_cnt_o  out  8  count of discarded samples/frames, saturating at 255

## Operation

- Tracker FSM states: HUNT, WAIT_R, WAIT_L. Reset state is HUNT. Nothing happens without sample_vld_i.
- HUNT:
  - strobe with ws_i=0 → latch the left sample, go to WAIT_R
  - strobe with ws_i=1 → ignore it, no count
- WAIT_R:
  - strobe with ws_i=1 → push {held left, this right} into the FIFO, go to WAIT_L
  - strobe with ws_i=0 → misalignment: replace the held left, drop_cnt +1, stay in WAIT_R
- WAIT_L:
  - strobe with ws_i=0 → latch the left sample, go to WAIT_R
  - strobe with ws_i=1 → misalignment: discard the sample, drop_cnt +1, go to HUNT
- Narrowing is applied per sample at latch time. The stored value is the converted OUT_W result.
- Default narrowing is truncation: out = sample_dat_i[IN_W-1 : IN_W-OUT_W].
- FIFO is first-word-fall-through. frame_l_o/frame_r_o always show the head entry, or zeros when empty.
- Pop occurs when frame_vld_o & frame_rdy_i.
- Push while full without a same-cycle pop: the frame is dropped, overflow_o is set, drop_cnt +1.
- Push and pop in the same cycle while full: both take effect and the occupancy is unchanged.
- Push and pop in the same cycle with one entry: the FIFO stays non-empty and the new frame becomes the head.
- drop_cnt_o saturates at 255. overflow_o and drop_cnt_o clear only on reset.

## Timing

- Reset values: frame_l_o=0, frame_r_o=0, frame_vld_o=0, sync_o=0, overflow_o=0, drop_cnt_o=0. FIFO is empty, state is HUNT, held left is 0.
- Reset asserted mid-frame discards the held left sample and all FIFO contents at the next clock edge.
- Latency: right strobe in cycle N with the FIFO empty → frame_vld_o=1 and data valid in cycle N+1.
- Pop in cycle N → the next head (or frame_vld_o=0) appears in cycle N+1.
- Strobes on consecutive cycles are fully supported, with no required gap.
- overflow_o and drop_cnt_o update in the cycle after the offending strobe.
- sync_o follows the registered state. It rises the cycle after the first left strobe in HUNT.
- frame_rdy_i may be low indefinitely. Frames are held, and overflow handling applies once the FIFO is full.

## Configuration

- Macro: FRAME_ASM_SAT_ROUND_EN.
- Defined: narrowing is round-half-up with saturation. The sample is sign-extended by 1 bit, then 2^(IN_W-OUT_W-1) is added, then the result is shifted right by IN_W-OUT_W. Results above the positive maximum clamp to 2^(OUT_W-1)-1.
- Undefined: plain truncation, no rounding adder, no saturation logic.

## Test plan

- Reset, then strobes L=0x123456 (ws=0) and R=0xFEDCBA (ws=1), frame_rdy_i=1 → one cycle after R: frame_vld_o=1, frame_l_o=0x1234, frame_r_o=0xFEDC; pop the cycle after; drop_cnt_o=0.
- Strobes in the order R, L, L, R, starting from HUNT → first R ignored (count 0); second L replaces the first (drop_cnt_o=1); one frame out with the second L's value; sync_o=1 from the cycle after the first L.
- frame_rdy_i=0, 5 complete frames with FIFO_DEPTH=4 → 4 frames held, overflow_o=1, drop_cnt_o=1; raising frame_rdy_i drains frames 1–4 in order, one per cycle.
- FIFO full while a push and a pop land in the same cycle → no overflow; occupancy stays 4; the head advances.
- With FRAME_ASM_SAT_ROUND_EN: inputs 0x000080, 0x000180, 0xFFFF80, 0x7FFFFF → outputs 0x0001, 0x0002, 0x0000, 0x7FFF. Without the macro: 0x0000, 0x0001, 0xFFFF, 0x7FFF.
- reset_n_i low for one cycle while in WAIT_R with 2 frames queued → next cycle: frame_vld_o=0, sync_o=0, counters 0; a following R strobe is ignored.
